// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the fetch unit: data widths, FSM state
// encoding, the timeout NOP value and the opcode field extraction.
package fetch_unit_pkg;

  localparam int ADDR_W          = 19;
  localparam int INSTR_W         = 19;
  localparam int OPC_W           = 5;
  localparam int TIMEOUT_DEFAULT = 15;
  localparam int CNT_W           = 8;

  localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = 19'h00000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } fetch_state_t;

  // The opcode occupies the top OPC_W bits of the instruction word.
  function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OPC_W];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus interfaces around the fetch unit: the control bus from the CU and the
// req/ack read channel to instruction memory.
interface control_bus_if;
  import fetch_unit_pkg::*;

  logic               load_ir;
  logic               load_pc;
  logic               inc_pc;
  logic [ADDR_W-1:0]  pc_in;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] ir;
  logic [OPC_W-1:0]   opcode;
  logic               busy;
  logic               fetch_done;
  logic               fetch_err;

  modport master (
    output load_ir, load_pc, inc_pc, pc_in,
    input  pc, ir, opcode, busy, fetch_done, fetch_err
  );

  modport slave (
    input  load_ir, load_pc, inc_pc, pc_in,
    output pc, ir, opcode, busy, fetch_done, fetch_err
  );
endinterface

interface imem_bus_if;
  import fetch_unit_pkg::*;

  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Program counter: load has priority over increment; increment wraps
// modulo 2^ADDR_W without any flag.
module pc_reg
  import fetch_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] d,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (load) begin
      pc <= d;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: executes CU fetch-side commands, owns PC and IR, and masters
// a req/ack instruction memory read with a bounded wait.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                 TIMEOUT   = TIMEOUT_DEFAULT,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  control_bus_if.slave  cbus,
  imem_bus_if.master    mem
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  fetch_state_t       state;
  logic [CNT_W-1:0]   wait_cnt;
  logic [INSTR_W-1:0] ir_reg;
  logic               mem_req_reg;
  logic [ADDR_W-1:0]  mem_addr_reg;
  logic               fetch_done_reg;
  logic               fetch_err_reg;
  logic [ADDR_W-1:0]  pc_val;
  logic               idle;
  logic               pc_load;
  logic               pc_inc;

  assign idle = (state == IDLE);

  // LOAD_IR outranks both PC commands; everything is ignored while busy.
  assign pc_load = idle && !cbus.load_ir && cbus.load_pc;
  assign pc_inc  = idle && !cbus.load_ir && !cbus.load_pc && cbus.inc_pc;

  pc_reg u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (pc_load),
    .inc   (pc_inc),
    .d     (cbus.pc_in),
    .pc    (pc_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      ir_reg         <= '0;
      mem_req_reg    <= 1'b0;
      mem_addr_reg   <= '0;
      fetch_done_reg <= 1'b0;
      fetch_err_reg  <= 1'b0;
    end else begin
      fetch_done_reg <= 1'b0;
      fetch_err_reg  <= 1'b0;
      case (state)
        IDLE: begin
          if (cbus.load_ir) begin
            mem_addr_reg <= pc_val;
            mem_req_reg  <= 1'b1;
            wait_cnt     <= '0;
            state        <= REQ;
          end
        end
        REQ: begin
          // An ACK in the expiry cycle still wins over the timeout.
          if (mem.mem_ack) begin
            ir_reg         <= mem.mem_rdata;
            mem_req_reg    <= 1'b0;
            fetch_done_reg <= 1'b1;
            state          <= DONE;
          end else if (wait_cnt == LAST_CNT) begin
            ir_reg        <= NOP_INSTR;
            mem_req_reg   <= 1'b0;
            fetch_err_reg <= 1'b1;
            state         <= ERR;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign cbus.pc         = pc_val;
  assign cbus.ir         = ir_reg;
  assign cbus.opcode     = opcode_of(ir_reg);
  assign cbus.busy       = !idle;
  assign cbus.fetch_done = fetch_done_reg;
  assign cbus.fetch_err  = fetch_err_reg;
  assign mem.mem_req     = mem_req_reg;
  assign mem.mem_addr    = mem_addr_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected fetch results are queued when a
// fetch is launched and compared when FETCH_DONE/FETCH_ERR appears.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int                 TIMEOUT = 15;
  localparam logic [INSTR_W-1:0] NOP     = 19'h00000;

  typedef struct packed {
    logic               err;
    logic [INSTR_W-1:0] ir;
    logic [ADDR_W-1:0]  addr;
  } exp_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  exp_t exp_q[$];

  control_bus_if cbus ();
  imem_bus_if    mem ();

  fetch_unit #(
    .TIMEOUT   (TIMEOUT),
    .NOP_INSTR (NOP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cbus  (cbus),
    .mem   (mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ack_after: REQ cycle (1-based) in which MEM_ACK is raised; 0 = never.
  task automatic run_fetch(input int ack_after, input logic [INSTR_W-1:0] data,
                           input logic [ADDR_W-1:0] exp_addr, input bit busy_cmds,
                           input bit with_inc);
    exp_t e;
    int   done_k;
    e.err  = (ack_after == 0) || (ack_after > TIMEOUT);
    e.ir   = e.err ? NOP : data;
    e.addr = exp_addr;
    exp_q.push_back(e);
    cbus.load_ir = 1'b1;
    cbus.inc_pc  = with_inc;
    tick();
    cbus.load_ir = 1'b0;
    cbus.inc_pc  = 1'b0;
    done_k = 0;
    for (int k = 1; k <= 40; k++) begin
      if (done_k == 0) begin
        chk("busy_in_req", 32'(cbus.busy), 32'd1);
        chk("req_held", 32'(mem.mem_req), 32'd1);
        chk("addr_held", 32'(mem.mem_addr), 32'(exp_addr));
        mem.mem_rdata = ~data;
        if (k == ack_after) begin
          mem.mem_ack   = 1'b1;
          mem.mem_rdata = data;
        end
        if (busy_cmds && k == 2) begin
          $display("note: LOAD_PC/INC_PC driven while BUSY (CU protocol violation, must be ignored)");
          cbus.load_pc = 1'b1;
          cbus.inc_pc  = 1'b1;
          cbus.pc_in   = 19'h55555;
        end
        tick();
        mem.mem_ack  = 1'b0;
        cbus.load_pc = 1'b0;
        cbus.inc_pc  = 1'b0;
        if (cbus.fetch_done || cbus.fetch_err) done_k = k;
      end
    end
    chk("fetch_completes", 32'(done_k != 0), 32'd1);
    e = exp_q.pop_front();
    chk("completion_cycle", 32'(done_k), e.err ? 32'(TIMEOUT) : 32'(ack_after));
    chk("fetch_done", 32'(cbus.fetch_done), 32'(!e.err));
    chk("fetch_err", 32'(cbus.fetch_err), 32'(e.err));
    chk("ir", 32'(cbus.ir), 32'(e.ir));
    chk("opcode", 32'(cbus.opcode), 32'(e.ir >> (INSTR_W - OPC_W)));
    chk("req_dropped", 32'(mem.mem_req), 32'd0);
    chk("pc_unchanged", 32'(cbus.pc), 32'(e.addr));
    tick();
    chk("done_single", 32'(cbus.fetch_done), 32'd0);
    chk("err_single", 32'(cbus.fetch_err), 32'd0);
    chk("idle_after", 32'(cbus.busy), 32'd0);
    $display("fetch addr=%05h ack_after=%0d err=%0d ir=%05h", exp_addr, ack_after, e.err, cbus.ir);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst_n         = 1'b0;
    cbus.load_ir  = 1'b0;
    cbus.load_pc  = 1'b0;
    cbus.inc_pc   = 1'b0;
    cbus.pc_in    = '0;
    mem.mem_ack   = 1'b0;
    mem.mem_rdata = '0;

    // Reset values
    #12;
    chk("rst_pc", 32'(cbus.pc), 32'd0);
    chk("rst_ir", 32'(cbus.ir), 32'd0);
    chk("rst_req", 32'(mem.mem_req), 32'd0);
    chk("rst_addr", 32'(mem.mem_addr), 32'd0);
    chk("rst_busy", 32'(cbus.busy), 32'd0);
    chk("rst_done", 32'(cbus.fetch_done), 32'd0);
    chk("rst_err", 32'(cbus.fetch_err), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    // Best-case fetch from PC=0; opcode = IR[18:14] = 0x2A5C3 >> 14 = 0x0A
    run_fetch(1, 19'h2A5C3, 19'h00000, 1'b0, 1'b0);
    chk("t1_ir", 32'(cbus.ir), 32'h2A5C3);
    chk("t1_opcode", 32'(cbus.opcode), 32'h0A);

    // PC load, wrap on increment, load outranks increment
    cbus.load_pc = 1'b1; cbus.pc_in = 19'h7FFFF;
    tick();
    cbus.load_pc = 1'b0;
    chk("pc_load_max", 32'(cbus.pc), 32'h7FFFF);
    cbus.inc_pc = 1'b1;
    tick();
    cbus.inc_pc = 1'b0;
    chk("pc_wrap", 32'(cbus.pc), 32'h0);
    cbus.load_pc = 1'b1; cbus.inc_pc = 1'b1; cbus.pc_in = 19'h00010;
    tick();
    cbus.load_pc = 1'b0; cbus.inc_pc = 1'b0;
    chk("pc_load_over_inc", 32'(cbus.pc), 32'h00010);

    // 7-cycle memory latency
    run_fetch(7, 19'h1F00D, 19'h00010, 1'b0, 1'b0);

    // ACK exactly at timeout expiry counts as success
    run_fetch(TIMEOUT, 19'h3ABCD, 19'h00010, 1'b0, 1'b0);

    // No ACK: timeout, then a late ACK in IDLE is ignored
    run_fetch(0, 19'h12345, 19'h00010, 1'b0, 1'b0);
    tick();
    mem.mem_ack = 1'b1; mem.mem_rdata = 19'h6DB6D;
    tick();
    mem.mem_ack = 1'b0;
    chk("late_ack_ir", 32'(cbus.ir), 32'(NOP));
    chk("late_ack_no_done", 32'(cbus.fetch_done), 32'd0);
    chk("late_ack_idle", 32'(cbus.busy), 32'd0);

    // Commands while busy are dropped; LOAD_IR outranks INC_PC
    run_fetch(4, 19'h0F0F0, 19'h00010, 1'b1, 1'b0);
    run_fetch(2, 19'h7C001, 19'h00010, 1'b0, 1'b1);

    // Async reset in the middle of a request
    cbus.load_pc = 1'b1; cbus.pc_in = 19'h00123;
    tick();
    cbus.load_pc = 1'b0;
    cbus.load_ir = 1'b1;
    tick();
    cbus.load_ir = 1'b0;
    chk("mid_req_addr", 32'(mem.mem_addr), 32'h00123);
    chk("mid_req_req", 32'(mem.mem_req), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_req_drop", 32'(mem.mem_req), 32'd0);
    chk("async_pc_clear", 32'(cbus.pc), 32'd0);
    chk("async_ir_clear", 32'(cbus.ir), 32'd0);
    chk("async_idle", 32'(cbus.busy), 32'd0);
    #2;
    rst_n         = 1'b1;
    mem.mem_ack   = 1'b1;
    mem.mem_rdata = 19'h5A5A5;
    tick();
    mem.mem_ack = 1'b0;
    chk("post_rst_ack_ir", 32'(cbus.ir), 32'd0);
    chk("post_rst_no_done", 32'(cbus.fetch_done), 32'd0);
    tick();
    chk("post_rst_no_done2", 32'(cbus.fetch_done), 32'd0);
    chk("post_rst_req", 32'(mem.mem_req), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
